uart_program_loader: RTL and testbench
======================================

UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud); legal values >= 4.
REQ-002 Parameter INSTR_MEM_DEPTH, default 128, instruction words in the downstream instruction memory; must be a power of two <= 256.
REQ-003 Parameter ADDR_W, default 7, imem_addr width; must equal log2(INSTR_MEM_DEPTH).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 enable  input  1  level; 1 = loader armed, 0 = loader idle.
REQ-007 uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-008 imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 imem_addr  output  ADDR_W  word address for the write.
REQ-010 imem_wdata  output  32  instruction word for the write.
REQ-011 cpu_hold  output  1  1 = CPU held in reset while a load is in progress.
REQ-012 load_done  output  1  1 = a complete program has been written.
REQ-013 frame_err  output  1  sticky; a received byte had stop bit = 0.

Function
REQ-014 uart_rx passes through a 2-flop synchronizer; every receiver decision uses the synchronized value only.
REQ-015 Receiver states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-016 RX_IDLE -> RX_START on a synchronized high-to-low transition; bit timer cleared.
REQ-017 RX_START samples at CLKS_PER_BIT/2: line high -> glitch, back to RX_IDLE, no byte produced; line low -> RX_DATA.
REQ-018 RX_DATA samples every CLKS_PER_BIT cycles after the mid-start sample; 8 samples, shifted LSB first.
REQ-019 RX_STOP samples the stop bit one bit time after bit 7: high -> byte-valid pulse for one cycle; low -> frame-error pulse, byte discarded; both cases -> RX_IDLE.
REQ-020 Loader states: L_IDLE, L_COUNT, L_DATA, L_DONE, L_ERROR.
REQ-021 L_IDLE: cpu_hold=0, load_done=0; enable=1 -> L_COUNT next cycle, frame_err cleared, word and byte counters cleared.
REQ-022 L_COUNT: first valid byte is the word count N; N=0 means INSTR_MEM_DEPTH words, N > INSTR_MEM_DEPTH is clamped to INSTR_MEM_DEPTH; -> L_DATA.
REQ-023 L_DATA: bytes assemble little-endian (byte0 -> wdata[7:0] ... byte3 -> wdata[31:24]).
REQ-024 On the cycle after the 4th byte-valid pulse, imem_we=1 for exactly one cycle, with imem_addr = current word index and imem_wdata = the assembled word; word index then increments and byte index resets to 0.
REQ-025 After the write of word N-1, the loader enters L_DONE on the following cycle; the index does not wrap.
REQ-026 L_DONE: load_done=1, cpu_hold=0; further received bytes are ignored; remains until enable=0.
REQ-027 A frame-error pulse in L_COUNT or L_DATA -> L_ERROR; frame_err=1; no write for the partial word.
REQ-028 L_ERROR: cpu_hold=1, load_done=0, no writes; exits only when enable=0.
REQ-029 cpu_hold=1 in L_COUNT, L_DATA and L_ERROR; 0 otherwise.
REQ-030 enable=0 in any state -> L_IDLE next cycle; a partial word is discarded and counters are cleared; frame_err is retained until the next L_IDLE -> L_COUNT transition.
REQ-031 The receiver runs regardless of loader state; bytes arriving in L_IDLE, L_DONE or L_ERROR are dropped.
REQ-032 imem_addr and imem_wdata may change only while imem_we=0, except in the write cycle itself.

Reset
REQ-033 rst_n=0 asynchronously forces both FSMs to their IDLE states, clears all counters and the shift register, and sets imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, load_done=0, frame_err=0; synchronizer flops reset to 1.
REQ-034 Reset asserted mid-frame or mid-load abandons the frame and the load; after release, the next start bit is received cleanly.

Verification (CLKS_PER_BIT=8)
REQ-035 Reset check: rst_n low with clk running -> all outputs 0; release with enable=0 -> outputs remain 0.
REQ-036 Single word: enable=1; bytes 0x01,0x13,0x05,0x00,0x00 -> one imem_we pulse, addr=0, wdata=0x00000513; then load_done=1, cpu_hold=0.
REQ-037 Full depth: N=0x00 followed by 512 bytes -> 128 writes, addresses 0..127 in order; last wdata matches; load_done=1; no 129th write.
REQ-038 Frame error: N=2, byte 2 of word 0 sent with stop bit=0 -> frame_err=1, no imem_we, cpu_hold stays 1; enable low then high -> frame_err=0, a new load writes address 0.
REQ-039 Glitch rejection: rx low for 3 cycles, then high -> no byte accepted, state unchanged; next valid byte is accepted normally.
REQ-040 Abort: drop enable after 2 bytes of word 1 -> cpu_hold=0 next cycle; re-enabling and sending N=1 plus 4 bytes writes address 0 with the new word only.

Source files
------------

// File: rtl/uart_program_loader.sv
// ---------------------------------------------------------------------------
// uart_program_loader
//   Receives a program over an 8N1 UART line and writes it, one 32-bit word
//   at a time, into a downstream instruction memory while the CPU is held in
//   reset. Stream format: one count byte N (0 means a full memory), followed
//   by N little-endian 32-bit words.
//
// Ports
//   clk         in   system clock, all state changes on the rising edge
//   rst_n       in   asynchronous active-low reset
//   enable      in   1 = loader armed, 0 = loader idle (also aborts a load)
//   uart_rx     in   asynchronous serial line, idle high, LSB first
//   imem_we     out  one-cycle instruction-memory write strobe
//   imem_addr   out  word address for the write
//   imem_wdata  out  instruction word for the write
//   cpu_hold    out  1 while a load is in progress or has failed
//   load_done   out  1 once a complete program has been written
//   frame_err   out  sticky; a byte with a low stop bit hit an active load
// ---------------------------------------------------------------------------
module uart_program_loader #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int INSTR_MEM_DEPTH = 128,
  parameter int ADDR_W          = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              frame_err
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  // One extra bit so the word index can reach N without wrapping.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_COUNT, L_DATA, L_DONE, L_ERROR} ld_state_t;

  // ---------------- receiver ----------------
  rx_state_t        r_rx_state;
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  logic [TMR_W-1:0] r_tmr;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_frame_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta     <= 1'b1;
      r_rx_sync     <= 1'b1;
      r_rx_prev     <= 1'b1;
      r_rx_state    <= RX_IDLE;
      r_tmr         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_pulse <= 1'b0;
    end else begin
      r_rx_meta     <= uart_rx;
      r_rx_sync     <= r_rx_meta;
      r_rx_prev     <= r_rx_sync;
      r_byte_valid  <= 1'b0;
      r_frame_pulse <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= RX_START;
            r_tmr      <= '0;
          end
        end
        RX_START: begin
          // Mid-start sample: a line already back high was only a glitch.
          if (r_tmr == TMR_HALF) begin
            r_tmr <= '0;
            if (r_rx_sync) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_DATA;
              r_bit_idx  <= '0;
            end
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_tmr == TMR_FULL) begin
            r_tmr   <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
            else                   r_bit_idx  <= r_bit_idx + 1'b1;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_tmr == TMR_FULL) begin
            r_tmr      <= '0;
            r_rx_state <= RX_IDLE;
            if (r_rx_sync) r_byte_valid  <= 1'b1;
            else           r_frame_pulse <= 1'b1;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- loader ----------------
  // Count byte: 0 and anything above the memory depth both mean a full load.
  logic [8:0]       w_n_ext;
  logic [CNT_W-1:0] w_n_clamped;

  assign w_n_ext     = {1'b0, r_shift};
  assign w_n_clamped = (w_n_ext == 9'd0 || w_n_ext > 9'(INSTR_MEM_DEPTH))
                       ? CNT_W'(INSTR_MEM_DEPTH) : CNT_W'(w_n_ext);

  ld_state_t        r_ld_state;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_word_idx;
  logic [1:0]       r_byte_idx;
  logic [23:0]      r_asm;
  logic             r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]      r_imem_wdata;
  logic             r_cpu_hold;
  logic             r_load_done;
  logic             r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_state   <= L_IDLE;
      r_word_cnt   <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_asm        <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_hold   <= 1'b0;
      r_load_done  <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      if (!enable) begin
        // Abort from anywhere; frame_err survives until the next arm.
        r_ld_state  <= L_IDLE;
        r_cpu_hold  <= 1'b0;
        r_load_done <= 1'b0;
        r_word_cnt  <= '0;
        r_word_idx  <= '0;
        r_byte_idx  <= '0;
      end else begin
        case (r_ld_state)
          L_IDLE: begin
            r_ld_state  <= L_COUNT;
            r_cpu_hold  <= 1'b1;
            r_frame_err <= 1'b0;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
          end
          L_COUNT: begin
            if (r_frame_pulse) begin
              r_ld_state  <= L_ERROR;
              r_frame_err <= 1'b1;
            end else if (r_byte_valid) begin
              r_word_cnt <= w_n_clamped;
              r_ld_state <= L_DATA;
            end
          end
          L_DATA: begin
            if (r_frame_pulse) begin
              r_ld_state  <= L_ERROR;
              r_frame_err <= 1'b1;
              r_byte_idx  <= '0;
            end else if (r_imem_we && r_word_idx == r_word_cnt) begin
              // The last word was written in the previous cycle.
              r_ld_state  <= L_DONE;
              r_cpu_hold  <= 1'b0;
              r_load_done <= 1'b1;
            end else if (r_byte_valid) begin
              if (r_byte_idx == 2'd3) begin
                r_imem_we    <= 1'b1;
                r_imem_addr  <= r_word_idx[ADDR_W-1:0];
                r_imem_wdata <= {r_shift, r_asm};
                r_word_idx   <= r_word_idx + 1'b1;
                r_byte_idx   <= '0;
              end else begin
                r_asm[{r_byte_idx, 3'b000} +: 8] <= r_shift;
                r_byte_idx <= r_byte_idx + 1'b1;
              end
            end
          end
          L_DONE:  ;
          L_ERROR: ;
          default: r_ld_state <= L_IDLE;
        endcase
      end
    end
  end

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign load_done  = r_load_done;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_program_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_program_loader
//   Self-checking bench for uart_program_loader at CLKS_PER_BIT = 8.
//   Expected memory writes are queued as words are sent and checked in
//   order when imem_we fires.
// ---------------------------------------------------------------------------
module tb_uart_program_loader;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        uart_rx = 1'b1;
  logic        imem_we;
  logic [6:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        frame_err;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLKS_PER_BIT    (CPB),
    .INSTR_MEM_DEPTH (128),
    .ADDR_W          (7)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .uart_rx    (uart_rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec    = 0;
  int  n_miscmp = 0;
  int  n_writes = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop_ok;
    idle(CPB);
    uart_rx = 1'b1;
    idle(CPB);
  endtask

  task automatic send_word(input logic [6:0] a, input logic [31:0] w);
    wr_t e;
    e.addr = a;
    e.data = w;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  // Write monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wr_t e;
      n_writes++;
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e.addr);
        check("wr_data", imem_wdata, e.data);
        $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
      end
    end
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    logic [31:0] w;

    // Reset
    idle(5);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_done", load_done, 0);
    check("rst_ferr", frame_err, 0);
    rst_n = 1'b1;
    idle(5);
    check("rel_we", imem_we, 0);
    check("rel_hold", cpu_hold, 0);
    check("rel_done", load_done, 0);
    check("rel_ferr", frame_err, 0);

    // Single word
    enable = 1'b1;
    idle(2);
    check("sw_hold_armed", cpu_hold, 1);
    base = n_writes;
    send_byte(8'h01, 1'b1);
    send_word(7'd0, 32'h0000_0513);
    idle(4);
    check("sw_writes", n_writes - base, 1);
    check("sw_done", load_done, 1);
    check("sw_hold", cpu_hold, 0);
    send_byte(8'hAA, 1'b1);
    idle(4);
    check("sw_done_ignore", n_writes - base, 1);
    check("sw_done_stays", load_done, 1);
    enable = 1'b0;
    idle(2);
    check("sw_done_clr", load_done, 0);

    // Full depth, N = 0
    enable = 1'b1;
    idle(2);
    base = n_writes;
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      send_word(i[6:0], w);
    end
    idle(4);
    check("fd_writes", n_writes - base, 128);
    check("fd_done", load_done, 1);
    check("fd_q_empty", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) send_byte(8'(i + 8'h40), 1'b1);
    idle(4);
    check("fd_no_129th", n_writes - base, 128);
    enable = 1'b0;
    idle(2);

    // Frame error in word 0, byte 2
    enable = 1'b1;
    idle(2);
    base = n_writes;
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    idle(4);
    check("fe_flag", frame_err, 1);
    check("fe_hold", cpu_hold, 1);
    check("fe_no_write", n_writes - base, 0);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    idle(4);
    check("fe_err_nowrite", n_writes - base, 0);
    check("fe_err_hold", cpu_hold, 1);
    check("fe_err_notdone", load_done, 0);
    enable = 1'b0;
    idle(2);
    check("fe_retained", frame_err, 1);
    check("fe_off_hold", cpu_hold, 0);
    enable = 1'b1;
    idle(2);
    check("fe_cleared", frame_err, 0);
    send_byte(8'h01, 1'b1);
    send_word(7'd0, 32'hDEAD_BEEF);
    idle(4);
    check("fe_reload_writes", n_writes - base, 1);
    check("fe_reload_done", load_done, 1);
    enable = 1'b0;
    idle(2);

    // Glitch rejection in L_COUNT
    enable = 1'b1;
    idle(2);
    base = n_writes;
    uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    idle(30);
    check("gl_hold", cpu_hold, 1);
    check("gl_ferr", frame_err, 0);
    check("gl_done", load_done, 0);
    send_byte(8'h01, 1'b1);
    send_word(7'd0, 32'h1234_5678);
    idle(4);
    check("gl_writes", n_writes - base, 1);
    check("gl_load_done", load_done, 1);
    enable = 1'b0;
    idle(2);

    // Abort after two bytes of word 1
    enable = 1'b1;
    idle(2);
    base = n_writes;
    send_byte(8'h03, 1'b1);
    send_word(7'd0, 32'hA5A5_0001);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("ab_hold_before", cpu_hold, 1);
    enable = 1'b0;
    idle(1);
    check("ab_hold_next", cpu_hold, 0);
    idle(2);
    enable = 1'b1;
    idle(2);
    send_byte(8'h01, 1'b1);
    send_word(7'd0, 32'hCAFE_F00D);
    idle(4);
    check("ab_writes", n_writes - base, 2);
    check("ab_done", load_done, 1);
    check("ab_q_empty", exp_q.size(), 0);
    enable = 1'b0;
    idle(2);

    // Reset mid-frame, then a clean load
    enable = 1'b1;
    idle(2);
    base = n_writes;
    send_byte(8'h01, 1'b1);
    uart_rx = 1'b0;
    idle(CPB * 3);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    idle(3);
    check("mr_hold", cpu_hold, 0);
    check("mr_done", load_done, 0);
    check("mr_addr", imem_addr, 0);
    rst_n = 1'b1;
    idle(3);
    check("mr_rearm", cpu_hold, 1);
    send_byte(8'h01, 1'b1);
    send_word(7'd0, 32'h0BAD_C0DE);
    idle(4);
    check("mr_writes", n_writes - base, 1);
    check("mr_load_done", load_done, 1);
    check("mr_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
